// File: rtl/event_panel_pkg.sv
// Shared constants for the event counter panel: key roles, count-source encoding, select width.
// No datapath, so no latency or backpressure.
package event_panel_pkg;

    localparam int KEY_NEXT  = 0;
    localparam int KEY_CLEAR = 1;
    localparam int KEY_HOLD  = 2;
    localparam int KEY_MODE  = 3;

    typedef enum logic {
        MODE_EVENT = 1'b0,
        MODE_TICK  = 1'b1
    } mode_t;

    // Channel-select width; a single channel still gets one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-key debouncer: level follows key_raw after DEB_CYCLES differing samples; press pulses with a rising level.
// Latency DEB_CYCLES cycles from a stable change; no backpressure.
module key_debouncer #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            press <= 1'b0;
            if (key_raw == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                // This sample is the DEB_CYCLES-th consecutive disagreement.
                level      <= key_raw;
                press      <= key_raw;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_counter_panel.sv
// Multi-channel event/timebase counter with TM1638 key control and a snapshot display register.
// Event count visible 3 edges after first high sample; key actions 1 cycle after press; no backpressure.
module event_counter_panel
    import event_panel_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int N_CH       = 4,
    parameter int CNT_W      = 32,
    parameter int N_KEYS     = 8,
    parameter int DEB_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           event_in,
    input  logic [N_KEYS-1:0]         keys_in,
    output logic                      tick,
    output logic [sel_w(N_CH)-1:0]    sel_ch,
    output logic [31:0]               display_data,
    output logic [7:0]                leds,
    output logic [7:0]                dots,
    output logic [N_CH-1:0]           ovf
);

    localparam int SEL_W = sel_w(N_CH);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ARM  = PRE_W'(TICK_DIV - 2);

    // ---------------- timebase ----------------
    logic [PRE_W-1:0] pre_cnt;

    // tick is registered one count early so it is high exactly while pre_cnt == TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            tick    <= (pre_cnt == PRE_ARM);
        end
    end

    // ---------------- event synchronisers ----------------
    logic [N_CH-1:0] ev_s1, ev_s2, ev_s3, ev_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_s1   <= '0;
            ev_s2   <= '0;
            ev_s3   <= '0;
            ev_rise <= '0;
        end else begin
            ev_s1   <= event_in;
            ev_s2   <= ev_s1;
            ev_s3   <= ev_s2;
            ev_rise <= ev_s2 & ~ev_s3;
        end
    end

    // ---------------- keys ----------------
    logic [N_KEYS-1:0] key_lvl;
    logic [3:0]        key_press;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        if (k < 4) begin : g_fn
            key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk     (clk),
                .reset   (reset),
                .key_raw (keys_in[k]),
                .level   (key_lvl[k]),
                .press   (key_press[k])
            );
        end else begin : g_aux
            logic press_unused;
            key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk     (clk),
                .reset   (reset),
                .key_raw (keys_in[k]),
                .level   (key_lvl[k]),
                .press   (press_unused)
            );
        end
    end

    if (N_KEYS >= 8) begin : g_dots_trunc
        assign dots = key_lvl[7:0];
    end else begin : g_dots_pad
        assign dots = {{(8 - N_KEYS){1'b0}}, key_lvl};
    end

    logic do_next, do_clear, do_hold, do_mode, do_wipe;

    always_comb begin
        do_next  = key_press[KEY_NEXT];
        do_clear = key_press[KEY_CLEAR];
        do_hold  = key_press[KEY_HOLD];
        do_mode  = key_press[KEY_MODE];
        do_wipe  = do_clear | do_mode;
    end

    // ---------------- counters ----------------
    logic [CNT_W-1:0] cnt  [N_CH];
    mode_t            mode [N_CH];
    logic [N_CH-1:0]  cnt_inc;

    always_comb begin
        cnt_inc = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_inc[ch] = (mode[ch] == MODE_TICK) ? tick : ev_rise[ch];
        end
    end

    // CLEAR/MODE use the sel_ch from before any coincident NEXT, and win over an increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt[ch]  <= '0;
                mode[ch] <= MODE_EVENT;
            end
            ovf <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (do_wipe && (sel_ch == SEL_W'(ch))) begin
                    cnt[ch] <= '0;
                    ovf[ch] <= 1'b0;
                    if (do_mode) begin
                        mode[ch] <= (mode[ch] == MODE_EVENT) ? MODE_TICK : MODE_EVENT;
                    end
                end else if (cnt_inc[ch]) begin
                    cnt[ch] <= cnt[ch] + 1'b1;
                    if (&cnt[ch]) begin
                        ovf[ch] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- selection, hold, snapshot ----------------
    logic hold;
    logic act_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_ch       <= '0;
            hold         <= 1'b0;
            act_q        <= 1'b0;
            display_data <= '0;
        end else begin
            if (do_next) begin
                sel_ch <= (sel_ch == SEL_LAST) ? '0 : sel_ch + 1'b1;
            end
            if (do_hold) begin
                hold <= ~hold;
            end
            act_q <= do_next | do_wipe;
            // act_q reloads after the action has landed, so it sees the new channel and cleared count.
            if (act_q || (tick && !hold)) begin
                display_data <= 32'(cnt[sel_ch]);
            end
        end
    end

    always_comb begin
        leds              = '0;
        leds[3'(sel_ch)]  = 1'b1;
        leds[7]           = hold;
    end

endmodule

// File: tb/tb_event_counter_panel.sv
// Directed self-checking bench for event_counter_panel with small parameters.
// Cycle index n counts edges since reset release; all expectations are hand-computed per edge.
module tb_event_counter_panel;

    localparam int TICK_DIV   = 10;
    localparam int N_CH       = 4;
    localparam int CNT_W      = 8;
    localparam int N_KEYS     = 8;
    localparam int DEB_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH-1:0]   event_in;
    logic [N_KEYS-1:0] keys_in;
    logic              tick;
    logic [1:0]        sel_ch;
    logic [31:0]       display_data;
    logic [7:0]        leds;
    logic [7:0]        dots;
    logic [N_CH-1:0]   ovf;

    int n;
    int n_assert;
    int n_fail;

    always #5 clk = ~clk;

    event_counter_panel #(
        .TICK_DIV   (TICK_DIV),
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .N_KEYS     (N_KEYS),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .event_in     (event_in),
        .keys_in      (keys_in),
        .tick         (tick),
        .sel_ch       (sel_ch),
        .display_data (display_data),
        .leds         (leds),
        .dots         (dots),
        .ovf          (ovf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) cyc();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, n);
        end
    endtask

    // Key high for 6 samples then low for 6: level rises at n0+4, action lands at n0+5.
    task automatic press_key(input int k);
        int n0;
        n0 = n;
        keys_in[k] = 1'b1;
        run_to(n0 + 6);
        keys_in[k] = 1'b0;
        run_to(n0 + 12);
    endtask

    initial begin
        n        = 0;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        event_in = '0;
        keys_in  = '0;
        repeat (3) cyc();

        check("rst_tick",    32'(tick), 32'd0);
        check("rst_sel",     32'(sel_ch), 32'd0);
        check("rst_display", display_data, 32'd0);
        check("rst_leds",    32'(leds), 32'h01);
        check("rst_dots",    32'(dots), 32'd0);
        check("rst_ovf",     32'(ovf), 32'd0);

        reset = 1'b0;
        n     = 0;

        // Timebase: tick high after edges 9, 19, 29, ...
        run_to(8);  check("tick_e8",  32'(tick), 32'd0);
        run_to(9);  check("tick_e9",  32'(tick), 32'd1);
        run_to(10); check("tick_e10", 32'(tick), 32'd0);
        run_to(19); check("tick_e19", 32'(tick), 32'd1);

        // Event pulses: ch0 x5 (increments at 29,35,41,47,60), ch1/ch2 x3.
        run_to(25); event_in = 4'b0111;
        run_to(28); event_in = 4'b0000;
        run_to(30); check("ev_first_inc_by_29", display_data, 32'd1);
        run_to(31); event_in = 4'b0111;
        run_to(34); event_in = 4'b0000;
        run_to(37); event_in = 4'b0111;
        run_to(40); check("ev_snap_40", display_data, 32'd2);
        event_in = 4'b0000;
        run_to(43); event_in = 4'b0001;
        run_to(46); event_in = 4'b0000;
        run_to(50); check("ev_snap_50", display_data, 32'd4);
        check("ev_ovf_clear", 32'(ovf), 32'd0);
        run_to(56); event_in = 4'b0001;
        run_to(59); event_in = 4'b0000;
        run_to(60); check("ev_inc_not_before_60", display_data, 32'd4);
        run_to(70); check("ev_snap_total", display_data, 32'd5);

        // NEXT: 3-cycle glitch ignored, 6-cycle press accepted.
        keys_in[0] = 1'b1;
        run_to(73); keys_in[0] = 1'b0;
        run_to(78); check("glitch_sel", 32'(sel_ch), 32'd0);
        check("glitch_dots", 32'(dots), 32'd0);
        keys_in[0] = 1'b1;
        run_to(82); check("deb_dots", 32'(dots), 32'h01);
        check("deb_sel_pending", 32'(sel_ch), 32'd0);
        run_to(83); check("next_sel", 32'(sel_ch), 32'd1);
        check("next_leds", 32'(leds), 32'h02);
        check("next_disp_pending", display_data, 32'd5);
        run_to(84); check("next_reload", display_data, 32'd3);
        keys_in[0] = 1'b0;
        run_to(88);
        press_key(0); check("next_sel2", 32'(sel_ch), 32'd2);
        press_key(0); check("next_sel3", 32'(sel_ch), 32'd3);
        press_key(0); check("next_wrap", 32'(sel_ch), 32'd0);
        check("next_wrap_leds", 32'(leds), 32'h01);
        check("next_wrap_disp", display_data, 32'd5);

        // MODE on ch0: clears counter, then counts ticks from edge 130.
        press_key(3);
        check("mode_clear_disp", display_data, 32'd0);
        run_to(2670); check("tick_snap_254", display_data, 32'd254);
        check("pre_wrap_ovf", 32'(ovf), 32'd0);
        run_to(2680); check("tick_snap_255", display_data, 32'd255);
        check("wrap_ovf", 32'(ovf), 32'h1);
        run_to(2690); check("wrap_snap_0", display_data, 32'd0);

        // CLEAR resets counter and sticky ovf.
        run_to(2730); keys_in[1] = 1'b1;
        run_to(2735); check("clear_ovf", 32'(ovf), 32'd0);
        check("clear_disp_pending", display_data, 32'd4);
        run_to(2736); check("clear_reload", display_data, 32'd0);
        keys_in[1] = 1'b0;
        run_to(2745); keys_in[1] = 1'b1;
        run_to(2750); check("clear_tick_snap", display_data, 32'd1);
        run_to(2751); check("clear_beats_tick", display_data, 32'd0);
        keys_in[1] = 1'b0;
        run_to(2760); check("clear_beats_tick_snap", display_data, 32'd0);

        // HOLD freezes snapshots; NEXT still reloads; second HOLD resumes.
        run_to(2762); keys_in[2] = 1'b1;
        run_to(2767); check("hold_leds", 32'(leds), 32'h81);
        run_to(2768); keys_in[2] = 1'b0;
        run_to(2769); event_in[1] = 1'b1;
        run_to(2772); event_in[1] = 1'b0;
        run_to(2780); check("hold_frozen", display_data, 32'd0);
        run_to(2782); keys_in[0] = 1'b1;
        run_to(2787); check("hold_next_sel", 32'(sel_ch), 32'd1);
        check("hold_next_leds", 32'(leds), 32'h82);
        run_to(2788); check("hold_next_reload", display_data, 32'd4);
        keys_in[0]  = 1'b0;
        event_in[1] = 1'b1;
        run_to(2791); event_in[1] = 1'b0;
        run_to(2792); keys_in[2] = 1'b1;
        run_to(2797); check("unhold_leds", 32'(leds), 32'h02);
        check("unhold_disp_pending", display_data, 32'd4);
        check("unhold_dots", 32'(dots), 32'h04);
        run_to(2798); keys_in[2] = 1'b0;
        run_to(2800); check("unhold_resume", display_data, 32'd5);

        // Reset mid-debounce and mid-count (counter0=7, sel_ch=2).
        run_to(2803); keys_in[0] = 1'b1;
        run_to(2808); check("pre_rst_sel", 32'(sel_ch), 32'd2);
        run_to(2809); keys_in[0] = 1'b0;
        run_to(2820); check("pre_rst_leds", 32'(leds), 32'h04);
        check("pre_rst_disp", display_data, 32'd3);
        keys_in[0]  = 1'b1;
        event_in[0] = 1'b1;
        run_to(2822); reset = 1'b1;
        run_to(2823);
        check("mid_rst_tick", 32'(tick), 32'd0);
        check("mid_rst_sel",  32'(sel_ch), 32'd0);
        check("mid_rst_disp", display_data, 32'd0);
        check("mid_rst_leds", 32'(leds), 32'h01);
        check("mid_rst_dots", 32'(dots), 32'd0);
        check("mid_rst_ovf",  32'(ovf), 32'd0);
        reset    = 1'b0;
        keys_in  = '0;
        event_in = '0;
        run_to(2831); check("post_rst_tick_early", 32'(tick), 32'd0);
        run_to(2832); check("post_rst_tick", 32'(tick), 32'd1);
        run_to(2834); check("post_rst_disp", display_data, 32'd0);
        check("post_rst_sel",  32'(sel_ch), 32'd0);
        check("post_rst_dots", 32'(dots), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
